// File: rtl/seq_divider4.sv
// ============================================================================
// Module   : seq_divider4
// Brief    : Unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] divisor_r;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // When the trial fits, the difference is below the divisor, so its low
  // WIDTH bits are exact even though the shifted remainder is WIDTH+1 wide.
  always_comb begin
    rem_shift = {rem_r, quo_r[WIDTH-1]};
    fits      = rem_shift >= {1'b0, divisor_r};
    trial     = rem_shift[WIDTH-1:0] - divisor_r;
    rem_next  = fits ? trial : rem_shift[WIDTH-1:0];
    quo_next  = {quo_r[WIDTH-2:0], fits};
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      rem_r     <= '0;
      quo_r     <= '0;
      divisor_r <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state     <= S_CALC;
            divisor_r <= Divisor;
            rem_r     <= '0;
            quo_r     <= Dividend;
            count     <= '0;
            Busy      <= 1'b1;
          end
        end
        S_CALC: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            state     <= S_DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= quo_next;
            Remainder <= rem_next;
            DivByZero <= (divisor_r == '0);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider4.sv
// ============================================================================
// Module   : tb_seq_divider4
// Brief    : Self-checking bench for seq_divider4 against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_divider4 #(.WIDTH(W)) dut (
    .Clock     (clk),
    .Resetn    (rst_n),
    .Start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (div_by_zero)
  );

  // Division by zero yields the all-ones quotient and returns the dividend.
  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts one operation from IDLE and returns the captured result; operands
  // and Start are scrambled while the operation is in flight.
  task automatic do_div(input int a, input int b, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic dbz, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(negedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      start = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor = W'($urandom);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    q = quotient; r = remainder; dbz = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
    end
    vectors++;
    if ({quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_result: q=%0h r=%0h required 0 0", quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      if (e <= 3) begin
        vectors++;
        if ({busy, done, quotient, remainder} !== {2'b10, 8'h00}) begin
          errors++;
          $display("FAIL basic_calc_e%0d: busy=%b done=%b q=%0d r=%0d required 1 0 0 0",
                   e, busy, done, quotient, remainder);
        end
      end else if (e == 4) begin
        vectors++;
        if ({busy, done, div_by_zero, quotient, remainder} !== {3'b010, 4'd3, 4'd1}) begin
          errors++;
          $display("FAIL basic_done: busy=%b done=%b dbz=%b q=%0d r=%0d required 0 1 0 3 1",
                   busy, done, div_by_zero, quotient, remainder);
        end
      end else begin
        vectors++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL basic_done_width: done=%b required 0", done);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int pa[4] = '{15, 7, 0, 15};
    int pb[4] = '{1, 9, 5, 15};
    int eq_d[4] = '{15, 0, 0, 1};
    int er_d[4] = '{0, 7, 0, 0};
    logic [W-1:0] q, r;
    logic dbz;
    int lat, eq, er;
    for (int i = 0; i < 4; i++) begin
      do_div(pa[i], pb[i], q, r, dbz, lat);
      vectors++;
      if (q !== W'(eq_d[i]) || r !== W'(er_d[i]) || dbz !== 1'b0 || lat != W) begin
        errors++;
        $display("FAIL sweep_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d required %0d %0d 0 %0d",
                 pa[i], pb[i], q, r, dbz, lat, eq_d[i], er_d[i], W);
      end
    end
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        ref_div(a, b, eq, er);
        do_div(a, b, q, r, dbz, lat);
        vectors++;
        if (q !== W'(eq) || r !== W'(er) || dbz !== (b == 0) || lat != W) begin
          errors++;
          $display("FAIL exhaustive_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d required %0d %0d %0d %0d",
                   a, b, q, r, dbz, lat, eq, er, (b == 0), W);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic dbz;
    int lat;
    do_div(9, 0, q, r, dbz, lat);
    vectors++;
    if (q !== 4'd15 || r !== 4'd9 || dbz !== 1'b1 || lat != W) begin
      errors++;
      $display("FAIL divzero_9_0: q=%0d r=%0d dbz=%b lat=%0d required 15 9 1 %0d",
               q, r, dbz, lat, W);
    end
    do_div(6, 3, q, r, dbz, lat);
    vectors++;
    if (q !== 4'd2 || r !== 4'd0 || dbz !== 1'b0 || lat != W) begin
      errors++;
      $display("FAIL divzero_clear_6_3: q=%0d r=%0d dbz=%b lat=%0d required 2 0 0 %0d",
               q, r, dbz, lat, W);
    end
  endtask

  task automatic test_start_held();
    int ndone = 0;
    int first_edge = -1;
    int second_edge = -1;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    for (int e = 0; e <= 12; e++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first_edge < 0) first_edge = e; else second_edge = e;
        vectors++;
        if (quotient !== 4'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
          errors++;
          $display("FAIL held_result_e%0d: q=%0d r=%0d dbz=%b required 3 1 0",
                   e, quotient, remainder, div_by_zero);
        end
      end
      if (e == 5 || e == 6) begin
        vectors++;
        if (busy !== (e == 6)) begin
          errors++;
          $display("FAIL held_busy_e%0d: busy=%b required %0d", e, busy, (e == 6));
        end
      end
      if ((e <= 3) || (e >= 6 && e <= 8)) begin
        dividend = W'($urandom); divisor = W'($urandom);
      end else if (e == 4) begin
        dividend = 4'd13; divisor = 4'd4;
      end
      if (e == 9) start = 1'b0;
    end
    vectors++;
    if (ndone != 2 || first_edge != 4 || second_edge != 10) begin
      errors++;
      $display("FAIL held_done_count: dones=%0d at %0d,%0d required 2 at 4,10",
               ndone, first_edge, second_edge);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic dbz;
    int lat;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL midreset_async: busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0) ndone++;
    end
    vectors++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midreset_no_done: done pulses=%0d required 0", ndone);
    end
    do_div(10, 3, q, r, dbz, lat);
    vectors++;
    if (q !== 4'd3 || r !== 4'd1 || dbz !== 1'b0 || lat != W) begin
      errors++;
      $display("FAIL midreset_restart: q=%0d r=%0d dbz=%b lat=%0d required 3 1 0 %0d",
               q, r, dbz, lat, W);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q, r;
    logic dbz;
    int lat, a, b, eq, er;
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ref_div(a, b, eq, er);
      do_div(a, b, q, r, dbz, lat);
      vectors++;
      if (q !== W'(eq) || r !== W'(er) || dbz !== (b == 0) || lat != W) begin
        errors++;
        $display("FAIL random_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d required %0d %0d %0d %0d",
                 a, b, q, r, dbz, lat, eq, er, (b == 0), W);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_div_zero();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider4.md
SEQ_DIVIDER4 -- requirements
Module: seq_divider4

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..8).
REQ-002 Port: Clock  input  1  rising-edge clock for all state.
REQ-003 Port: Resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: Start  input  1  request; sampled on the rising edge of Clock, acted on only in IDLE.
REQ-005 Port: Dividend  input  WIDTH  unsigned dividend; sampled on the edge that accepts Start.
REQ-006 Port: Divisor  input  WIDTH  unsigned divisor; sampled on the edge that accepts Start.
REQ-007 Port: Quotient  output  WIDTH  registered result.
REQ-008 Port: Remainder  output  WIDTH  registered result.
REQ-009 Port: Busy  output  1  high while in CALC.
REQ-010 Port: Done  output  1  one-cycle pulse; result valid.
REQ-011 Port: DivByZero  output  1  registered flag: last accepted Divisor was 0.
REQ-012 The design SHALL use one clock; reset SHALL be asynchronous and active-low on Resetn.

Function
REQ-013 The divider SHALL implement restoring division: unsigned Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor when Divisor != 0.
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 IDLE->CALC on an edge with Start=1: latch Divisor; partial remainder R=0; working quotient Q=Dividend; iteration count=0.
REQ-016 IDLE SHALL hold state while Start=0.
REQ-017 Each CALC edge SHALL do one iteration.
- {R,Q} shifts left 1 bit.
- Trial T = R_shifted - Divisor, computed WIDTH+1 bits wide.
- T >= 0: R=T[WIDTH-1:0], Q[0]=1.
- T < 0: R=R_shifted, Q[0]=0.
REQ-018 CALC SHALL perform exactly WIDTH iterations; the WIDTH-th iteration edge SHALL move to DONE and load Quotient/Remainder from the final Q/R.
REQ-019 Latency: if Start is accepted at edge 0, Done SHALL be high from edge WIDTH to edge WIDTH+1 (exactly one cycle).
REQ-020 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-021 Start SHALL be ignored in CALC and DONE; there is no queuing.
REQ-022 Quotient, Remainder and DivByZero SHALL change only on entry to DONE and hold until the next DONE entry; intermediate Q/R SHALL never appear on them.
REQ-023 Divisor=0 SHALL still take WIDTH iterations.
- Result SHALL be Quotient = all ones, Remainder = Dividend (natural restoring result).
- DivByZero=1 SHALL be set at DONE entry; otherwise DivByZero=0.
REQ-024 Busy SHALL be 1 exactly in CALC.
REQ-025 Done SHALL be 1 exactly in DONE.
REQ-026 Dividend/Divisor changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-027 Resetn=0 SHALL immediately, without waiting for Clock, force:
- state=IDLE;
- Quotient=0, Remainder=0, R=Q=0, count=0;
- Busy=0, Done=0, DivByZero=0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation; no Done pulse SHALL follow.
REQ-029 The first Start accepted after Resetn returns high SHALL behave as REQ-015.

Verification
REQ-030 WIDTH=4, Dividend=13, Divisor=4, Start pulsed at edge 0 -> Busy=1 for edges 1..3; at edge 4 Done=1, Quotient=3, Remainder=1, DivByZero=0; at edge 5 Done=0.
REQ-031 Sweep at WIDTH=4: 15/1 -> Q=15 R=0; 7/9 -> Q=0 R=7; 0/5 -> Q=0 R=0; 15/15 -> Q=1 R=0. Exhaustive all 256 pairs SHALL be checked against the reference model.
REQ-032 9/0 -> Done at edge 4, Quotient=15, Remainder=9, DivByZero=1; a following 6/3 -> Q=2 R=0 with DivByZero cleared.
REQ-033 Start held high for 10 cycles with 13/4 -> exactly one Done per accepted start.
- Accepts occur at edges 0 and 6: accept, 4 CALC edges, DONE, IDLE re-accepts.
- Operand changes during CALC do not alter the 3/1 result.
REQ-034 Resetn pulled low between edges 2 and 3 of a 13/4 operation -> all outputs 0 asynchronously; no Done pulse; a new 10/3 start afterwards -> Q=3 R=1.
